// File: rtl/rvvi_packetizer.sv
// rvvi_packetizer
// Captures compressed-RVVI trace vectors into a small FIFO and streams one
// framed packet per record as 32-bit words over a valid/ready handshake.
// Absent fields (unwritten GPR/FPR halves, unused CSR slots) are removed
// before the record is stored.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   valid      rvvi holds a complete trace record this cycle
//   rvvi       packed record {CSRs, Registers, Required}
//   TReady     sink accepts the current word
//   TValid     TData/TLast valid
//   TData      packet word (header {seq, len}, then little-endian payload)
//   TLast      final word of the packet
//   Overflow   sticky: a record was dropped since reset
//   DropCount  dropped records, saturating at 0xFFFF
module rvvi_packetizer #(
    parameter int XLEN       = 64,
    parameter int MAX_CSRS   = 3,
    parameter int DEPTH      = 2,
    parameter int RVVI_WIDTH = 72 + 5*XLEN + MAX_CSRS*(XLEN+16)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [RVVI_WIDTH-1:0] rvvi,
    input  logic                  TReady,
    output logic                  TValid,
    output logic [31:0]           TData,
    output logic                  TLast,
    output logic                  Overflow,
    output logic [15:0]           DropCount
);

    localparam int REQ_W    = 56 + 3*XLEN;
    localparam int HALF_W   = 8 + XLEN;
    localparam int CSR_W    = 16 + XLEN;
    localparam int REG_LO   = REQ_W;
    localparam int CSR_LO   = REQ_W + 2*HALF_W;
    localparam int GWEN_BIT = 163 + XLEN;
    localparam int FWEN_BIT = 164 + XLEN;
    localparam int CNT_LO   = 168 + XLEN;
    localparam int NWORDS   = (RVVI_WIDTH + 31) / 32;
    localparam int PAY_W    = NWORDS * 32;
    localparam int IDX_W    = $clog2(NWORDS);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int NCSR_W   = $clog2(MAX_CSRS + 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

    // FIFO storage: records are stored already compacted, with length and last word index
    logic [NWORDS-1:0][31:0] mem_pay_r  [DEPTH];
    logic [15:0]             mem_len_r  [DEPTH];
    logic [IDX_W-1:0]        mem_last_r [DEPTH];

    logic [PTR_W-1:0] wr_r, rd_r, nxt_rd_s;
    logic [CNT_W-1:0] count_r;
    state_t           state_r, nxt_state_s;
    logic [IDX_W-1:0] idx_r, nxt_idx_s;
    logic [15:0]      seq_r, nxt_seq_s, drop_r;
    logic             overflow_r, tvalid_r, last_r;
    logic [31:0]      data_r;

    logic              g_s, f_s, full_s, push_s, pop_s, drop_s;
    logic [11:0]       cnt_raw_s;
    logic [NCSR_W-1:0] n_s;
    logic [PAY_W-1:0]  pay_s;
    logic [15:0]       len_s;
    logic [IDX_W-1:0]  last_s;
    int                off_fpr_s, off_csr_s, len_int_s;
    logic [31:0]       nxt_data_s;
    logic              nxt_tvalid_s, nxt_last_s;

    // Compact the incoming record: present fields packed back to back from the LSB
    always_comb begin
        g_s       = rvvi[GWEN_BIT];
        f_s       = rvvi[FWEN_BIT];
        cnt_raw_s = rvvi[CNT_LO +: 12];
        n_s       = (cnt_raw_s > 12'(MAX_CSRS)) ? NCSR_W'(MAX_CSRS) : NCSR_W'(cnt_raw_s);
        off_fpr_s = REQ_W + (g_s ? HALF_W : 0);
        off_csr_s = off_fpr_s + (f_s ? HALF_W : 0);
        pay_s     = PAY_W'(rvvi[REQ_W-1:0]);
        pay_s     = pay_s | (g_s ? (PAY_W'(rvvi[REG_LO +: HALF_W]) << REQ_W) : {PAY_W{1'b0}});
        pay_s     = pay_s | (f_s ? (PAY_W'(rvvi[REG_LO+HALF_W +: HALF_W]) << off_fpr_s) : {PAY_W{1'b0}});
        for (int i = 0; i < MAX_CSRS; i++) begin
            pay_s = pay_s | ((i < int'(n_s))
                    ? (PAY_W'(rvvi[CSR_LO + i*CSR_W +: CSR_W]) << (off_csr_s + i*CSR_W))
                    : {PAY_W{1'b0}});
        end
        len_int_s = REQ_W/8 + (int'(g_s) + int'(f_s)) * (HALF_W/8) + int'(n_s) * (CSR_W/8);
        len_s     = 16'(len_int_s);
        last_s    = IDX_W'((len_int_s + 3) / 4 - 1);
    end

    // Full is judged after the same-cycle pop, so a record arriving on the final handshake is kept
    always_comb begin
        full_s = (count_r == CNT_W'(DEPTH));
        push_s = valid && (!full_s || pop_s);
        drop_s = valid && full_s && !pop_s;
    end

    // FIFO payload storage (no reset needed: contents are only read when count says so)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pay_r[wr_r]  <= pay_s;
            mem_len_r[wr_r]  <= len_s;
            mem_last_r[wr_r] <= last_s;
        end else begin
            mem_pay_r[wr_r]  <= mem_pay_r[wr_r];
        end
    end

    // FIFO pointers, occupancy and drop statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_r       <= {PTR_W{1'b0}};
            rd_r       <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
            drop_r     <= 16'h0000;
        end else begin
            wr_r    <= push_s ? wr_r + PTR_W'(1) : wr_r;
            rd_r    <= nxt_rd_s;
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            if (drop_s) begin
                overflow_r <= 1'b1;
                drop_r     <= (drop_r == 16'hFFFF) ? drop_r : drop_r + 16'h0001;
            end else begin
                overflow_r <= overflow_r;
                drop_r     <= drop_r;
            end
        end
    end

    // Next-state logic; HDR/PAY always present a word, so TReady alone marks a handshake
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = idx_r;
        nxt_rd_s    = rd_r;
        pop_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (count_r != {CNT_W{1'b0}}) nxt_state_s = S_HDR;
                else                          nxt_state_s = S_IDLE;
            end
            S_HDR: begin
                if (TReady) begin
                    nxt_state_s = S_PAY;
                    nxt_idx_s   = {IDX_W{1'b0}};
                end else begin
                    nxt_state_s = S_HDR;
                end
            end
            S_PAY: begin
                if (TReady) begin
                    if (idx_r == mem_last_r[rd_r]) begin
                        pop_s     = 1'b1;
                        nxt_rd_s  = rd_r + PTR_W'(1);
                        nxt_idx_s = {IDX_W{1'b0}};
                        // only records already stored count; a same-cycle write waits in IDLE
                        if (count_r > CNT_W'(1)) nxt_state_s = S_HDR;
                        else                     nxt_state_s = S_IDLE;
                    end else begin
                        nxt_idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    nxt_state_s = S_PAY;
                end
            end
            default: nxt_state_s = S_IDLE;
        endcase
    end

    assign nxt_seq_s = pop_s ? seq_r + 16'h0001 : seq_r;

    // Output word for the next cycle, looked up from the post-transition state and FIFO head
    always_comb begin
        nxt_tvalid_s = 1'b0;
        nxt_data_s   = 32'h0000_0000;
        nxt_last_s   = 1'b0;
        case (nxt_state_s)
            S_HDR: begin
                nxt_tvalid_s = 1'b1;
                nxt_data_s   = {nxt_seq_s, mem_len_r[nxt_rd_s]};
            end
            S_PAY: begin
                nxt_tvalid_s = 1'b1;
                nxt_data_s   = mem_pay_r[nxt_rd_s][nxt_idx_s];
                nxt_last_s   = (nxt_idx_s == mem_last_r[nxt_rd_s]);
            end
            default: begin
                nxt_tvalid_s = 1'b0;
                nxt_data_s   = 32'h0000_0000;
                nxt_last_s   = 1'b0;
            end
        endcase
    end

    // FSM state, word index, sequence number and registered stream outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            idx_r    <= {IDX_W{1'b0}};
            seq_r    <= 16'h0000;
            tvalid_r <= 1'b0;
            data_r   <= 32'h0000_0000;
            last_r   <= 1'b0;
        end else begin
            state_r  <= nxt_state_s;
            idx_r    <= nxt_idx_s;
            seq_r    <= nxt_seq_s;
            tvalid_r <= nxt_tvalid_s;
            data_r   <= nxt_data_s;
            last_r   <= nxt_last_s;
        end
    end

    assign TValid    = tvalid_r;
    assign TData     = data_r;
    assign TLast     = last_r;
    assign Overflow  = overflow_r;
    assign DropCount = drop_r;

endmodule

// File: tb/tb_rvvi_packetizer.sv
module tb_rvvi_packetizer;

    localparam int XLEN     = 64;
    localparam int MAX_CSRS = 3;
    localparam int DEPTH    = 2;
    localparam int RW       = 72 + 5*XLEN + MAX_CSRS*(XLEN+16);

    logic          clk = 1'b0;
    logic          reset, valid, TReady, TValid, TLast, Overflow;
    logic [RW-1:0] rvvi;
    logic [31:0]   TData;
    logic [15:0]   DropCount;

    always #5 clk = ~clk;

    rvvi_packetizer #(.XLEN(XLEN), .MAX_CSRS(MAX_CSRS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .valid(valid), .rvvi(rvvi), .TReady(TReady),
        .TValid(TValid), .TData(TData), .TLast(TLast),
        .Overflow(Overflow), .DropCount(DropCount)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // current record, kept as separate fields
    logic [247:0]  rec_req;
    logic [71:0]   rec_gpr, rec_fpr;
    logic [79:0]   rec_csr [3];
    bit            rec_g, rec_f;
    int            rec_n;
    logic [RW-1:0] rec_vec, inject_vec;

    // expected and observed word streams
    logic [31:0] exp_q[$];
    bit          exp_last_q[$];
    logic [15:0] seq_exp;
    logic [31:0] got_q[$];
    bit          got_last_q[$];
    int          recv_cycles, first_valid_cycle, stall_changes;
    bit          timed_out;

    task pack_vec();
        rec_vec = {rec_csr[2], rec_csr[1], rec_csr[0], rec_fpr, rec_gpr, rec_req};
    endtask

    task make_rec(input bit g, input bit f, input int cnt_raw);
        logic [639:0] tmp;
        for (int i = 0; i < 20; i++) tmp[i*32 +: 32] = $urandom;
        rec_req    = tmp[247:0];
        rec_gpr    = tmp[319:248];
        rec_fpr    = tmp[391:320];
        rec_csr[0] = tmp[471:392];
        rec_csr[1] = tmp[551:472];
        rec_csr[2] = tmp[631:552];
        rec_req[227]     = g;
        rec_req[228]     = f;
        rec_req[243:232] = 12'(cnt_raw);
        rec_g = g;
        rec_f = f;
        rec_n = (cnt_raw > MAX_CSRS) ? MAX_CSRS : cnt_raw;
        pack_vec();
    endtask

    // Reference model: list the present fields as bytes, then frame them
    task model_append();
        logic [7:0]  b[$];
        logic [31:0] w;
        int          words;
        b = {};
        for (int k = 0; k < 31; k++) b.push_back(rec_req[8*k +: 8]);
        if (rec_g) for (int k = 0; k < 9; k++) b.push_back(rec_gpr[8*k +: 8]);
        if (rec_f) for (int k = 0; k < 9; k++) b.push_back(rec_fpr[8*k +: 8]);
        for (int i = 0; i < rec_n; i++)
            for (int k = 0; k < 10; k++) b.push_back(rec_csr[i][8*k +: 8]);
        exp_q.push_back({seq_exp, 16'(b.size())});
        exp_last_q.push_back(1'b0);
        words = (b.size() + 3) / 4;
        for (int wi = 0; wi < words; wi++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4*wi + k < b.size()) w[8*k +: 8] = b[4*wi + k];
            exp_q.push_back(w);
            exp_last_q.push_back(wi == words - 1);
        end
        seq_exp = seq_exp + 16'd1;
    endtask

    function automatic int diff_count(output int first_idx);
        int n = 0;
        int m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        first_idx = -1;
        for (int i = 0; i < m; i++) begin
            if (got_q[i] !== exp_q[i] || got_last_q[i] != exp_last_q[i]) begin
                n++;
                if (first_idx < 0) first_idx = i;
            end
        end
        if (got_q.size() != exp_q.size()) begin
            n++;
            if (first_idx < 0) first_idx = m;
        end
        return n;
    endfunction

    task do_reset();
        reset  = 1'b0;
        valid  = 1'b0;
        TReady = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q = {};
        exp_last_q = {};
        seq_exp = 16'd0;
        @(negedge clk);
    endtask

    // one valid pulse; returns at the negedge of the following cycle
    task send();
        @(negedge clk);
        valid = 1'b1;
        rvvi  = rec_vec;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Collect words until npkts TLast handshakes. mode 1: random TReady.
    // Otherwise TReady=1 except stall_len cycles once stall_at words were taken.
    task recv(input int npkts, input int mode, input int stall_at, input int stall_len, input bit inject);
        int          done, cyc, stall_left;
        bit          prev_stall, injected;
        logic [31:0] prev_data;
        logic        prev_last;
        got_q = {}; got_last_q = {};
        done = 0; cyc = 0; stall_left = stall_len; prev_stall = 1'b0; injected = 1'b0;
        prev_data = 32'h0; prev_last = 1'b0;
        stall_changes = 0; first_valid_cycle = -1; timed_out = 1'b0;
        while (done < npkts && !timed_out) begin
            @(negedge clk);
            cyc++;
            valid = 1'b0;
            if (prev_stall && (TValid !== 1'b1 || TData !== prev_data || TLast !== prev_last))
                stall_changes++;
            if (TValid === 1'b1 && first_valid_cycle < 0) first_valid_cycle = cyc;
            if (mode == 1) TReady = ($urandom_range(0, 2) != 0);
            else if (stall_left > 0 && got_q.size() == stall_at) begin
                TReady = 1'b0;
                stall_left--;
            end else TReady = 1'b1;
            prev_stall = (TValid === 1'b1) && !TReady;
            prev_data  = TData;
            prev_last  = TLast;
            if (TValid === 1'b1 && TReady) begin
                got_q.push_back(TData);
                got_last_q.push_back(TLast);
                if (TLast === 1'b1) begin
                    done++;
                    if (inject && !injected) begin
                        valid = 1'b1;
                        rvvi  = inject_vec;
                        injected = 1'b1;
                    end
                end
            end
            if (cyc >= 2000) timed_out = 1'b1;
        end
        recv_cycles = cyc;
    endtask

    task test_reset();
        reset = 1'b0; valid = 1'b0; TReady = 1'b0; rvvi = '0;
        #12;
        total_cnt++; if (TValid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", TValid); else pass_cnt++;
        total_cnt++; if (TData !== 32'h0) $display("FAIL reset_tdata: got %h want 0", TData); else pass_cnt++;
        total_cnt++; if (TLast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", TLast); else pass_cnt++;
        total_cnt++; if (Overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", Overflow); else pass_cnt++;
        total_cnt++; if (DropCount !== 16'h0) $display("FAIL reset_dropcount: got %0d want 0", DropCount); else pass_cnt++;
        do_reset();
    endtask

    task test_gpr_only();
        int nd, di;
        make_rec(1'b1, 1'b0, 0);
        model_append();
        send();
        total_cnt++; if (TValid !== 1'b0) $display("FAIL gpr_latency_early: TValid %b want 0 at t+1", TValid); else pass_cnt++;
        recv(1, 0, 0, 0, 1'b0);
        total_cnt++; if (first_valid_cycle !== 1) $display("FAIL gpr_latency: header at t+%0d want t+2", first_valid_cycle + 1); else pass_cnt++;
        total_cnt++; if (got_q[0] !== 32'h0000_0028) $display("FAIL gpr_header: got %h want 00000028", got_q[0]); else pass_cnt++;
        total_cnt++; if ({got_q[10], got_q[9], got_q[8][31:24]} !== rec_gpr) $display("FAIL gpr_bytes: got %h want %h", {got_q[10], got_q[9], got_q[8][31:24]}, rec_gpr); else pass_cnt++;
        total_cnt++; if (recv_cycles !== 11) $display("FAIL gpr_cycles: got %0d want 11", recv_cycles); else pass_cnt++;
        nd = diff_count(di);
        total_cnt++; if (nd !== 0 || timed_out) $display("FAIL gpr_packet: %0d diffs first %0d, got %0d words want %0d, timeout %b", nd, di, got_q.size(), exp_q.size(), timed_out); else pass_cnt++;
        exp_q = {}; exp_last_q = {};
    endtask

    task test_full();
        int nd, di;
        make_rec(1'b1, 1'b1, 3);
        model_append();
        send();
        recv(1, 0, 0, 0, 1'b0);
        total_cnt++; if (got_q[0][15:0] !== 16'd79) $display("FAIL full_len: got %0d want 79", got_q[0][15:0]); else pass_cnt++;
        total_cnt++; if (got_q.size() !== 21) $display("FAIL full_words: got %0d want 21", got_q.size()); else pass_cnt++;
        total_cnt++; if (got_q[20][31:24] !== 8'h00) $display("FAIL full_pad: got %h want 00", got_q[20][31:24]); else pass_cnt++;
        nd = diff_count(di);
        total_cnt++; if (nd !== 0 || timed_out) $display("FAIL full_packet: %0d diffs first %0d, got %0d words want %0d", nd, di, got_q.size(), exp_q.size()); else pass_cnt++;
        exp_q = {}; exp_last_q = {};
    endtask

    task test_fpr_only();
        int nd, di;
        make_rec(1'b0, 1'b1, 0);
        rec_fpr[7:0] = 8'h05;
        pack_vec();
        model_append();
        send();
        recv(1, 0, 0, 0, 1'b0);
        total_cnt++; if (got_q[0][15:0] !== 16'd40) $display("FAIL fpr_len: got %0d want 40", got_q[0][15:0]); else pass_cnt++;
        total_cnt++; if (got_q[8][31:24] !== 8'h05) $display("FAIL fpr_addr: got %h want 05", got_q[8][31:24]); else pass_cnt++;
        total_cnt++; if ({got_q[10], got_q[9]} !== rec_fpr[71:8]) $display("FAIL fpr_value: got %h want %h", {got_q[10], got_q[9]}, rec_fpr[71:8]); else pass_cnt++;
        nd = diff_count(di);
        total_cnt++; if (nd !== 0 || timed_out) $display("FAIL fpr_packet: %0d diffs first %0d", nd, di); else pass_cnt++;
        exp_q = {}; exp_last_q = {};
    endtask

    task test_clamp();
        int nd, di;
        make_rec(1'b1, 1'b0, 4095);
        model_append();
        send();
        recv(1, 0, 0, 0, 1'b0);
        total_cnt++; if (got_q[0][15:0] !== 16'd70) $display("FAIL clamp_len: got %0d want 70", got_q[0][15:0]); else pass_cnt++;
        nd = diff_count(di);
        total_cnt++; if (nd !== 0 || timed_out) $display("FAIL clamp_packet: %0d diffs first %0d", nd, di); else pass_cnt++;
        exp_q = {}; exp_last_q = {};
    endtask

    task test_stall();
        int nd, di;
        make_rec(1'b1, 1'b1, 2);
        model_append();
        send();
        recv(1, 0, 4, 5, 1'b0);
        total_cnt++; if (stall_changes !== 0) $display("FAIL stall_stable: %0d changes during stall, want 0", stall_changes); else pass_cnt++;
        total_cnt++; if (recv_cycles !== exp_q.size() + 5) $display("FAIL stall_cycles: got %0d want %0d", recv_cycles, exp_q.size() + 5); else pass_cnt++;
        nd = diff_count(di);
        total_cnt++; if (nd !== 0 || timed_out) $display("FAIL stall_packet: %0d diffs first %0d, got %0d words want %0d", nd, di, got_q.size(), exp_q.size()); else pass_cnt++;
        exp_q = {}; exp_last_q = {};
    endtask

    task test_overflow();
        int nd, di;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            make_rec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            if (i < 2) model_append();
            @(negedge clk);
            valid = 1'b1;
            rvvi  = rec_vec;
        end
        @(negedge clk);
        valid = 1'b0;
        total_cnt++; if (Overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", Overflow); else pass_cnt++;
        total_cnt++; if (DropCount !== 16'd2) $display("FAIL ovf_dropcount: got %0d want 2", DropCount); else pass_cnt++;
        recv(2, 0, 0, 0, 1'b0);
        total_cnt++; if (got_q[0][31:16] !== 16'd0) $display("FAIL ovf_seq0: got %0d want 0", got_q[0][31:16]); else pass_cnt++;
        nd = diff_count(di);
        total_cnt++; if (nd !== 0 || timed_out) $display("FAIL ovf_packets: %0d diffs first %0d, got %0d words want %0d", nd, di, got_q.size(), exp_q.size()); else pass_cnt++;
        exp_q = {}; exp_last_q = {};
    endtask

    task test_full_pop();
        int nd, di;
        do_reset();
        make_rec(1'b1, 1'b0, 1); model_append(); send();
        make_rec(1'b0, 1'b1, 2); model_append(); send();
        make_rec(1'b1, 1'b1, 0); model_append(); inject_vec = rec_vec;
        recv(3, 0, 0, 0, 1'b1);
        total_cnt++; if (DropCount !== 16'd0 || Overflow !== 1'b0) $display("FAIL fullpop_nodrop: drops %0d ovf %b want 0 0", DropCount, Overflow); else pass_cnt++;
        nd = diff_count(di);
        total_cnt++; if (nd !== 0 || timed_out) $display("FAIL fullpop_packets: %0d diffs first %0d, got %0d words want %0d", nd, di, got_q.size(), exp_q.size()); else pass_cnt++;
        exp_q = {}; exp_last_q = {};
    endtask

    task test_reset_mid();
        int nd, di, words, cyc;
        bit  saw_last;
        make_rec(1'b1, 1'b1, 3);
        send();
        TReady = 1'b1; words = 0; cyc = 0; saw_last = 1'b0;
        while (words < 4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (TValid === 1'b1) begin
                words++;
                if (TLast === 1'b1) saw_last = 1'b1;
            end
        end
        total_cnt++; if (words !== 4 || saw_last) $display("FAIL rstmid_prefix: words %0d want 4, early TLast %b want 0", words, saw_last); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++; if (TValid !== 1'b0 || TLast !== 1'b0) $display("FAIL rstmid_async: TValid %b TLast %b want 0 0", TValid, TLast); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        exp_q = {}; exp_last_q = {}; seq_exp = 16'd0;
        @(negedge clk);
        make_rec(1'b0, 1'b0, 1);
        model_append();
        send();
        recv(1, 0, 0, 0, 1'b0);
        total_cnt++; if (got_q[0][31:16] !== 16'd0) $display("FAIL rstmid_seq: got %0d want 0", got_q[0][31:16]); else pass_cnt++;
        nd = diff_count(di);
        total_cnt++; if (nd !== 0 || timed_out) $display("FAIL rstmid_packet: %0d diffs first %0d, got %0d words want %0d", nd, di, got_q.size(), exp_q.size()); else pass_cnt++;
        exp_q = {}; exp_last_q = {};
    endtask

    task test_random();
        int nd, di;
        for (int it = 0; it < 24; it++) begin
            make_rec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5));
            model_append();
            send();
            recv(1, 1, 0, 0, 1'b0);
            nd = diff_count(di);
            total_cnt++;
            if (nd !== 0 || timed_out || stall_changes !== 0)
                $display("FAIL random_%0d: %0d diffs first %0d, got %0d words want %0d, stall changes %0d", it, nd, di, got_q.size(), exp_q.size(), stall_changes);
            else pass_cnt++;
            exp_q = {}; exp_last_q = {};
        end
    endtask

    initial begin
        reset = 1'b0; valid = 1'b0; TReady = 1'b0; rvvi = '0; seq_exp = 16'd0;
        test_reset();
        test_gpr_only();
        test_full();
        test_fpr_only();
        test_clamp();
        test_stall();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
